// File: rtl/common_defs.sv
// Shared definitions for the wave register file: register map, general-register
// count, FSM encoding and a width helper.
package common_defs;

   // Registers 0..NUM_GPR-1 are writable; 28..31 are generated on read.
   localparam int NUM_GPR       = 28;
   localparam int REG_BLOCK_ID  = 28;
   localparam int REG_BLOCK_DIM = 29;
   localparam int REG_THREAD_ID = 30;
   localparam int REG_ZERO      = 31;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } rf_state_e;

   // clog2 that never returns 0, so a 1-entry dimension still gets a 1-bit field.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/wave_reg_file_if.sv
// Read-request / read-response / write bus of the wave register file.
interface wave_reg_file_if
   import common_defs::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int LANES      = 16,
   parameter int WAVE_SIZE  = 32,
   parameter int NUM_WAVES  = 4
);
   localparam int CYCLES = (WAVE_SIZE + LANES - 1) / LANES;
   localparam int WS_W   = clog2_min1(NUM_WAVES);
   localparam int CY_W   = clog2_min1(CYCLES);
   localparam int RA_W   = clog2_min1(NUM_REGS);

   // read request
   logic                        req_valid;
   logic                        req_ready;
   logic [WS_W-1:0]             req_slot;
   logic [31:0]                 req_wave_id;
   logic [CY_W-1:0]             req_cycle;
   logic [RA_W-1:0]             rm;
   logic [RA_W-1:0]             rn;
   // read response
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [LANES*DATA_WIDTH-1:0] rm_data;
   logic [LANES*DATA_WIDTH-1:0] rn_data;
   // write
   logic                        wr_en;
   logic [WS_W-1:0]             wr_slot;
   logic [CY_W-1:0]             wr_cycle;
   logic [RA_W-1:0]             rd;
   logic [LANES-1:0]            wr_mask;
   logic [LANES*DATA_WIDTH-1:0] wr_data;

   modport master (
      output req_valid, req_slot, req_wave_id, req_cycle, rm, rn,
      output rsp_ready,
      output wr_en, wr_slot, wr_cycle, rd, wr_mask, wr_data,
      input  req_ready, rsp_valid, rm_data, rn_data
   );

   modport slave (
      input  req_valid, req_slot, req_wave_id, req_cycle, rm, rn,
      input  rsp_ready,
      input  wr_en, wr_slot, wr_cycle, rd, wr_mask, wr_data,
      output req_ready, rsp_valid, rm_data, rn_data
   );

endinterface

// File: rtl/wave_reg_file_lane.sv
// One SIMD lane of the wave register file: general-register storage for every
// resident slot/cycle, read-only register generation and the registered
// operand outputs. Optional feature macro: WAVE_RF_BYPASS_EN (same-cycle
// write data forwarded into a matching read).
module wave_rf_lane
   import common_defs::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int LANES      = 16,
   parameter int WAVE_SIZE  = 32,
   parameter int NUM_WAVES  = 4,
   parameter int CYCLES     = 2,
   parameter int WS_W       = 2,
   parameter int CY_W       = 1,
   parameter int RA_W       = 5,
   parameter int LANE_IDX   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   // read side
   input  logic                  accept,
   input  logic [WS_W-1:0]       req_slot,
   input  logic [CY_W-1:0]       req_cycle,
   input  logic [31:0]           req_wave_id,
   input  logic [RA_W-1:0]       rm,
   input  logic [RA_W-1:0]       rn,
   input  logic [31:0]           block_id,
   input  logic [31:0]           block_dim,
   // write side (wr_fire already qualified by enable and a writable rd)
   input  logic                  wr_fire,
   input  logic [WS_W-1:0]       wr_slot,
   input  logic [CY_W-1:0]       wr_cycle,
   input  logic [RA_W-1:0]       rd,
   input  logic                  wr_mask_bit,
   input  logic [DATA_WIDTH-1:0] wr_data,
   // registered operands
   output logic [DATA_WIDTH-1:0] rm_q,
   output logic [DATA_WIDTH-1:0] rn_q
);
   localparam int NUM_ENT = NUM_WAVES * CYCLES;
   localparam int ENT_W   = clog2_min1(NUM_ENT);
   localparam int GA_W    = clog2_min1(NUM_GPR);

   // storage entry = slot * CYCLES + cycle
   logic [DATA_WIDTH-1:0] mem [NUM_ENT][NUM_GPR];

   logic [ENT_W-1:0]      rd_ent, wr_ent;
   logic                  rd_ok, wr_ok;
   logic [31:0]           thread_id;
   logic [DATA_WIDTH-1:0] rm_nxt, rn_nxt;
`ifdef WAVE_RF_BYPASS_EN
   logic                  wr_hit;
`endif

   // Entry decode; a cycle index beyond CYCLES addresses nothing.
   always_comb begin
      rd_ok     = (int'(req_slot) < NUM_WAVES) && (int'(req_cycle) < CYCLES);
      wr_ok     = (int'(wr_slot)  < NUM_WAVES) && (int'(wr_cycle)  < CYCLES);
      rd_ent    = ENT_W'(int'(req_slot) * CYCLES + int'(req_cycle));
      wr_ent    = ENT_W'(int'(wr_slot)  * CYCLES + int'(wr_cycle));
      // global thread index, wraps in 32 bits before sign extension
      thread_id = req_wave_id * 32'(WAVE_SIZE) + 32'(req_cycle) * 32'(LANES)
                + 32'(LANE_IDX);
   end

   function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [RA_W-1:0] ra);
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      if (int'(ra) < NUM_GPR) begin
         if (rd_ok) v = mem[rd_ent][ra[GA_W-1:0]];
`ifdef WAVE_RF_BYPASS_EN
         if (wr_hit && (rd == ra)) v = wr_data;
`endif
      end else if (int'(ra) == REG_BLOCK_ID) begin
         v = DATA_WIDTH'($signed(block_id));
      end else if (int'(ra) == REG_BLOCK_DIM) begin
         v = DATA_WIDTH'($signed(block_dim));
      end else if (int'(ra) == REG_THREAD_ID) begin
         v = DATA_WIDTH'($signed(thread_id));
      end
      return v;
   endfunction

   // Operand selection for both source ports.
   always_comb begin
`ifdef WAVE_RF_BYPASS_EN
      wr_hit = wr_fire && wr_mask_bit && wr_ok && rd_ok && (wr_ent == rd_ent);
`endif
      rm_nxt = read_reg(rm);
      rn_nxt = read_reg(rn);
   end

   // General-register writes, masked per lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < NUM_ENT; e++)
            for (int g = 0; g < NUM_GPR; g++)
               mem[e][g] <= '0;
      end else if (wr_fire && wr_mask_bit && wr_ok) begin
         mem[wr_ent][rd[GA_W-1:0]] <= wr_data;
      end
   end

   // Operands are captured at request acceptance and held until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rm_q <= '0;
         rn_q <= '0;
      end else if (accept) begin
         rm_q <= rm_nxt;
         rn_q <= rn_nxt;
      end
   end

endmodule

// File: rtl/wave_reg_file.sv
// Wave register file top: request/response FSM, write qualification, sticky
// illegal-write flag and LANES instances of wave_rf_lane.
// Optional feature macro: WAVE_RF_BYPASS_EN (a read accepted in the same cycle
// as a matching write returns the new data; otherwise the pre-write value).
module wave_reg_file
   import common_defs::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int LANES      = 16,
   parameter int WAVE_SIZE  = 32,
   parameter int NUM_WAVES  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [31:0]         block_id,
   input  logic [31:0]         block_dim,
   wave_reg_file_if.slave      bus,
   output logic                wr_illegal
);
   localparam int CYCLES = (WAVE_SIZE + LANES - 1) / LANES;
   localparam int WS_W   = clog2_min1(NUM_WAVES);
   localparam int CY_W   = clog2_min1(CYCLES);
   localparam int RA_W   = clog2_min1(NUM_REGS);

   rf_state_e                        state;
   logic                             rsp_valid_q;
   logic                             accept;
   logic                             wr_legal;
   logic                             wr_fire;
   logic [LANES-1:0][DATA_WIDTH-1:0] rm_lane, rn_lane;

   // A new request can enter when idle or when the pending response drains now.
   assign bus.req_ready = enable && ((state == IDLE) || (rsp_valid_q && bus.rsp_ready));
   assign accept        = bus.req_valid && bus.req_ready;
   assign wr_legal      = int'(bus.rd) < NUM_GPR;
   assign wr_fire       = bus.wr_en && enable && wr_legal;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rm_data   = rm_lane;
   assign bus.rn_data   = rn_lane;

   // Response FSM; everything freezes while enable is low so a pending
   // response is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
      end else if (accept) begin
         state       <= RESP;
         rsp_valid_q <= 1'b1;
      end else if (enable && (state == RESP) && bus.rsp_ready) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
      end
   end

   // Sticky flag for writes aimed at read-only registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                   wr_illegal <= 1'b0;
      else if (bus.wr_en && enable && !wr_legal) wr_illegal <= 1'b1;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      wave_rf_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .LANES      (LANES),
         .WAVE_SIZE  (WAVE_SIZE),
         .NUM_WAVES  (NUM_WAVES),
         .CYCLES     (CYCLES),
         .WS_W       (WS_W),
         .CY_W       (CY_W),
         .RA_W       (RA_W),
         .LANE_IDX   (l)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .accept      (accept),
         .req_slot    (bus.req_slot),
         .req_cycle   (bus.req_cycle),
         .req_wave_id (bus.req_wave_id),
         .rm          (bus.rm),
         .rn          (bus.rn),
         .block_id    (block_id),
         .block_dim   (block_dim),
         .wr_fire     (wr_fire),
         .wr_slot     (bus.wr_slot),
         .wr_cycle    (bus.wr_cycle),
         .rd          (bus.rd),
         .wr_mask_bit (bus.wr_mask[l]),
         .wr_data     (bus.wr_data[l*DATA_WIDTH +: DATA_WIDTH]),
         .rm_q        (rm_lane[l]),
         .rn_q        (rn_lane[l])
      );
   end

endmodule
